// File: rtl/clock_pkg.sv
// Shared constants, encodings and wrap-around helpers for the clock timekeeper.
// Hours run 0..11, minutes and seconds 0..59, alarm minutes in steps of ten.
package clock_pkg;

   localparam logic [3:0] MAX_HOUR    = 4'd11;
   localparam logic [5:0] MAX_MIN     = 6'd59;
   localparam logic [5:0] MAX_SEC     = 6'd59;
   localparam logic [5:0] AL_MIN_STEP = 6'd10;
   localparam logic [5:0] AL_MIN_LAST = 6'd50;

   typedef enum logic {
      TGT_TIME  = 1'b0,
      TGT_ALARM = 1'b1
   } target_t;

   typedef enum logic {
      IDLE = 1'b0,
      RING = 1'b1
   } alarm_state_t;

   function automatic logic [3:0] inc_hour(input logic [3:0] h);
      return (h >= MAX_HOUR) ? 4'd0 : h + 4'd1;
   endfunction

   function automatic logic [5:0] inc_60(input logic [5:0] v);
      return (v >= MAX_SEC) ? 6'd0 : v + 6'd1;
   endfunction

   function automatic logic [5:0] inc_al_min(input logic [5:0] v);
      return (v >= AL_MIN_LAST) ? 6'd0 : v + AL_MIN_STEP;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus run-length filter for one raw push button.
// A new level is accepted after DEBOUNCE_CYCLES consecutive differing samples.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 250_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1_r;
   logic          sync2_r;
   logic          level_r;
   logic          press_r;
   logic [CW-1:0] cnt_r;

   // synchronize, then count how long the synchronized level disagrees with the accepted one
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         level_r <= 1'b0;
         press_r <= 1'b0;
         cnt_r   <= {CW{1'b0}};
      end else begin
         sync1_r <= btn_raw;
         sync2_r <= sync1_r;
         press_r <= 1'b0;
         if (sync2_r == level_r) begin
            cnt_r <= {CW{1'b0}};
         end else if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt_r   <= {CW{1'b0}};
            level_r <= sync2_r;
            press_r <= sync2_r;
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
      end
   end

   assign level = level_r;
   assign press = press_r;

endmodule

// File: rtl/clock_timekeeper.sv
// 12-hour timekeeper with 1 Hz prescaler, button setting, ten-minute alarm and
// renderer refresh strobe. Presses win over a coincident tick, which is deferred.
module clock_timekeeper
   import clock_pkg::*;
#(
   parameter int TICK_DIV        = 25_000_000,
   parameter int DEBOUNCE_CYCLES = 250_000,
   parameter int RING_SECONDS    = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_hour,
   input  logic       btn_min,
   input  logic       btn_mode,
   input  logic       alarm_en,
   output logic [3:0] hour,
   output logic [5:0] minute,
   output logic [5:0] second,
   output logic [3:0] al_hour,
   output logic [5:0] al_minute,
   output logic       slow_clk,
   output logic       set_alarm,
   output logic       alarm_ring
);

   localparam int PW   = $clog2(TICK_DIV);
   localparam int HALF = TICK_DIV / 2;
   localparam int HW   = $clog2(HALF + 1);
   localparam int RW   = $clog2(RING_SECONDS + 1);

   logic [PW-1:0] presc_r;
   logic          tick_pending_r;
   logic          slow_r;
   logic [HW-1:0] half_cnt_r;
   logic [3:0]    hour_r;
   logic [5:0]    minute_r;
   logic [5:0]    second_r;
   logic [3:0]    al_hour_r;
   logic [5:0]    al_minute_r;
   target_t       target_r;
   alarm_state_t  state_r;
   logic [RW-1:0] ring_cnt_r;
   logic          en1_r;
   logic          en_sync_r;

   logic          hour_press_s;
   logic          min_press_s;
   logic          mode_press_s;
   logic [2:0]    level_unused_s;
   logic          tick_s;
   logic          any_press_s;
   logic          time_min_s;
   logic          tick_due_s;
   logic          apply_tick_s;
   logic          pending_next_s;
   logic          match_s;
   logic [3:0]    hour_nx_s;
   logic [5:0]    min_nx_s;
   logic [5:0]    sec_nx_s;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hour (
      .clk(clk), .reset(reset), .btn_raw(btn_hour), .level(level_unused_s[0]), .press(hour_press_s)
   );
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_min (
      .clk(clk), .reset(reset), .btn_raw(btn_min), .level(level_unused_s[1]), .press(min_press_s)
   );
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk(clk), .reset(reset), .btn_raw(btn_mode), .level(level_unused_s[2]), .press(mode_press_s)
   );

   // tick arbitration against presses, and the time one second later
   always_comb begin
      tick_s         = (presc_r == PW'(TICK_DIV - 1));
      any_press_s    = hour_press_s | min_press_s | mode_press_s;
      time_min_s     = min_press_s & (target_r == TGT_TIME);
      tick_due_s     = tick_s | tick_pending_r;
      apply_tick_s   = tick_due_s & ~any_press_s;
      pending_next_s = tick_due_s & any_press_s & ~time_min_s;
      sec_nx_s       = inc_60(second_r);
      if (second_r == MAX_SEC) begin
         min_nx_s = inc_60(minute_r);
         if (minute_r == MAX_MIN) begin
            hour_nx_s = inc_hour(hour_r);
         end else begin
            hour_nx_s = hour_r;
         end
      end else begin
         min_nx_s  = minute_r;
         hour_nx_s = hour_r;
      end
      match_s = (hour_nx_s == al_hour_r) && (min_nx_s == al_minute_r) &&
                (sec_nx_s == 6'd0) && en_sync_r;
   end

   // prescaler; a TIME minute press restarts the second
   always_ff @(posedge clk) begin
      if (!reset) begin
         presc_r        <= {PW{1'b0}};
         tick_pending_r <= 1'b0;
         en1_r          <= 1'b0;
         en_sync_r      <= 1'b0;
      end else begin
         tick_pending_r <= pending_next_s;
         en1_r          <= alarm_en;
         en_sync_r      <= en1_r;
         if (time_min_s || tick_s) begin
            presc_r <= {PW{1'b0}};
         end else begin
            presc_r <= presc_r + PW'(1);
         end
      end
   end

   // renderer strobe: high for HALF cycles from each applied tick
   always_ff @(posedge clk) begin
      if (!reset) begin
         slow_r     <= 1'b0;
         half_cnt_r <= {HW{1'b0}};
      end else if (apply_tick_s) begin
         slow_r     <= 1'b1;
         half_cnt_r <= HW'(HALF - 1);
      end else if (slow_r) begin
         if (half_cnt_r == {HW{1'b0}}) begin
            slow_r <= 1'b0;
         end else begin
            half_cnt_r <= half_cnt_r - HW'(1);
         end
      end else begin
         half_cnt_r <= {HW{1'b0}};
      end
   end

   // time, alarm setting and set target
   always_ff @(posedge clk) begin
      if (!reset) begin
         hour_r      <= 4'd0;
         minute_r    <= 6'd0;
         second_r    <= 6'd0;
         al_hour_r   <= 4'd0;
         al_minute_r <= 6'd0;
         target_r    <= TGT_TIME;
      end else if (any_press_s) begin
         if (target_r == TGT_TIME) begin
            if (hour_press_s) hour_r <= inc_hour(hour_r);
            if (min_press_s) begin
               minute_r <= inc_60(minute_r);
               second_r <= 6'd0;
            end
         end else begin
            if (hour_press_s) al_hour_r <= inc_hour(al_hour_r);
            if (min_press_s) al_minute_r <= inc_al_min(al_minute_r);
         end
         if (mode_press_s && (state_r == IDLE)) begin
            target_r <= (target_r == TGT_TIME) ? TGT_ALARM : TGT_TIME;
         end
      end else if (apply_tick_s) begin
         hour_r   <= hour_nx_s;
         minute_r <= min_nx_s;
         second_r <= sec_nx_s;
      end
   end

   // alarm FSM: only a tick can start ringing
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= IDLE;
         ring_cnt_r <= {RW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (apply_tick_s && match_s) begin
                  state_r    <= RING;
                  ring_cnt_r <= {RW{1'b0}};
               end
            end
            RING: begin
               if (mode_press_s || !en_sync_r) begin
                  state_r <= IDLE;
               end else if (apply_tick_s) begin
                  if (ring_cnt_r == RW'(RING_SECONDS - 1)) begin
                     state_r <= IDLE;
                  end else begin
                     ring_cnt_r <= ring_cnt_r + RW'(1);
                  end
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign hour       = hour_r;
   assign minute     = minute_r;
   assign second     = second_r;
   assign al_hour    = al_hour_r;
   assign al_minute  = al_minute_r;
   assign slow_clk   = slow_r;
   assign set_alarm  = target_r;
   assign alarm_ring = (state_r == RING);

endmodule

// File: tb/tb_clock_timekeeper.sv
// Randomized and directed bench for clock_timekeeper against a seconds-since-midnight
// model of the clock, compared on every falling edge.
module tb_clock_timekeeper;

   localparam int TD   = 10;
   localparam int DB   = 4;
   localparam int RS   = 60;
   localparam int HALF = TD / 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_hour = 1'b0;
   logic       btn_min = 1'b0;
   logic       btn_mode = 1'b0;
   logic       alarm_en = 1'b0;
   logic [3:0] hour;
   logic [5:0] minute;
   logic [5:0] second;
   logic [3:0] al_hour;
   logic [5:0] al_minute;
   logic       slow_clk;
   logic       set_alarm;
   logic       alarm_ring;

   clock_timekeeper #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .RING_SECONDS(RS)) dut (
      .clk(clk), .reset(reset), .btn_hour(btn_hour), .btn_min(btn_min), .btn_mode(btn_mode),
      .alarm_en(alarm_en), .hour(hour), .minute(minute), .second(second), .al_hour(al_hour),
      .al_minute(al_minute), .slow_clk(slow_clk), .set_alarm(set_alarm), .alarm_ring(alarm_ring)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // model: time as seconds since 0:00:00, alarm as hour and minute
   int          m_t, m_alh, m_alm, m_phase, m_slow_left, m_ring_ticks;
   bit          m_alarm_tgt, m_ring, m_pend, m_valid, m_en1, m_en2;
   bit          m_s1[3], m_s2[3], m_lvl[3], m_press[3];
   logic [DB-1:0] m_win[3];
   int          m_fill[3];

   task automatic model_step();
      bit raw[3];
      bit hp, mp, dp, tick, due, tmin, applied, ring_old, en_old, cur;
      int h, m, s;
      raw[0] = btn_hour; raw[1] = btn_min; raw[2] = btn_mode;
      if (!reset) begin
         m_t = 0; m_alh = 0; m_alm = 0; m_phase = 0; m_slow_left = 0; m_ring_ticks = 0;
         m_alarm_tgt = 0; m_ring = 0; m_pend = 0; m_en1 = 0; m_en2 = 0; m_valid = 1;
         for (int b = 0; b < 3; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_press[b] = 0; m_win[b] = '0; m_fill[b] = 0;
         end
         return;
      end
      hp = m_press[0]; mp = m_press[1]; dp = m_press[2];
      tick = (m_phase == TD - 1);
      due = tick || m_pend;
      tmin = mp && !m_alarm_tgt;
      ring_old = m_ring;
      en_old = m_en2;
      applied = 0;
      h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
      if (hp || mp || dp) begin
         if (!m_alarm_tgt) begin
            if (hp) h = (h + 1) % 12;
            if (mp) begin m = (m + 1) % 60; s = 0; end
            m_t = h * 3600 + m * 60 + s;
         end else begin
            if (hp) m_alh = (m_alh + 1) % 12;
            if (mp) m_alm = (m_alm + 10) % 60;
         end
         if (dp && !ring_old) m_alarm_tgt = !m_alarm_tgt;
         m_pend = due && !tmin;
      end else begin
         applied = due;
         m_pend = 0;
         if (due) m_t = (m_t + 1) % 43200;
      end
      m_phase = tmin ? 0 : (m_phase + 1) % TD;
      if (applied) m_slow_left = HALF;
      else if (m_slow_left > 0) m_slow_left--;
      if (ring_old) begin
         if (dp || !en_old) m_ring = 0;
         else if (applied) begin
            m_ring_ticks++;
            if (m_ring_ticks == RS) m_ring = 0;
         end
      end else if (applied && en_old && (m_t == m_alh * 3600 + m_alm * 60)) begin
         m_ring = 1;
         m_ring_ticks = 0;
      end
      m_en2 = m_en1;
      m_en1 = alarm_en;
      // a level is accepted once the last DB synchronized samples all oppose it
      for (int b = 0; b < 3; b++) begin
         cur = m_s2[b];
         m_s2[b] = m_s1[b];
         m_s1[b] = raw[b];
         m_win[b] = {m_win[b][DB-2:0], cur};
         if (m_fill[b] < DB) m_fill[b]++;
         m_press[b] = 0;
         if (m_fill[b] == DB && m_win[b] == {DB{~m_lvl[b]}}) begin
            m_lvl[b] = !m_lvl[b];
            m_press[b] = m_lvl[b];
         end
      end
   endtask

   initial begin
      m_valid = 0;
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // per-cycle comparison of every output against the model
   initial begin
      logic [3:0] e_h, e_alh;
      logic [5:0] e_m, e_s, e_alm;
      logic       e_slow, e_set, e_ring;
      forever begin
         @(negedge clk);
         if (m_valid) begin
            e_h = 4'(m_t / 3600); e_m = 6'(( m_t / 60) % 60); e_s = 6'(m_t % 60);
            e_alh = 4'(m_alh); e_alm = 6'(m_alm);
            e_slow = (m_slow_left > 0); e_set = m_alarm_tgt; e_ring = m_ring;
            checks++;
            if (hour !== e_h || minute !== e_m || second !== e_s || al_hour !== e_alh ||
                al_minute !== e_alm || slow_clk !== e_slow || set_alarm !== e_set ||
                alarm_ring !== e_ring) begin
               failures++;
               if (failures <= 20)
                  $display("FAIL model_compare t=%0t got %0d:%0d:%0d al=%0d:%0d slow=%b set=%b ring=%b want %0d:%0d:%0d al=%0d:%0d slow=%b set=%b ring=%b",
                           $time, hour, minute, second, al_hour, al_minute, slow_clk, set_alarm, alarm_ring,
                           e_h, e_m, e_s, e_alh, e_alm, e_slow, e_set, e_ring);
            end
         end
      end
   end

   task automatic lit(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== 32'(exp)) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic set_btn(input int b, input bit v);
      case (b)
         0: btn_hour = v;
         1: btn_min = v;
         2: btn_mode = v;
         default: begin btn_hour = v; btn_min = v; end
      endcase
   endtask

   // raise at a falling edge; it is applied on the 7th rising edge, and we return 8 edges later
   task automatic press(input int b);
      set_btn(b, 1'b1);
      repeat (7) @(posedge clk);
      @(negedge clk);
      set_btn(b, 1'b0);
      repeat (8) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   // alarm 1:10, time 1:09:00 with presc restarted 8 edges ago
   task automatic setup_110();
      alarm_en = 1'b1;
      do_reset();
      press(2); press(0); press(1); press(2); press(0);
      repeat (9) press(1);
   endtask

   initial begin
      int hi;
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // free run from reset
      repeat (10) @(negedge clk);
      lit("first_tick_second", 32'(second), 1);
      hi = 0;
      for (int k = 0; k < 10; k++) begin
         if (slow_clk) hi++;
         @(negedge clk);
      end
      lit("slow_clk_high_cycles", 32'(hi), 5);
      repeat (580) @(negedge clk);
      lit("run600_minute", 32'(minute), 1);
      lit("run600_second", 32'(second), 0);

      // hour wrap from 11:59:58
      do_reset();
      repeat (11) press(0);
      repeat (59) press(1);
      repeat (572) @(negedge clk);
      lit("preload_hour", 32'(hour), 11);
      lit("preload_minute", 32'(minute), 59);
      lit("preload_second", 32'(second), 58);
      repeat (20) @(negedge clk);
      lit("wrap_hour", 32'(hour), 0);
      lit("wrap_minute", 32'(minute), 0);
      lit("wrap_second", 32'(second), 0);

      // bounce then hold: exactly one minute increment
      btn_min = 1'b1; @(negedge clk);
      btn_min = 1'b0; @(negedge clk);
      btn_min = 1'b1; @(negedge clk);
      btn_min = 1'b0; @(negedge clk);
      btn_min = 1'b1;
      repeat (7) @(posedge clk);
      @(negedge clk);
      lit("bounce_minute", 32'(minute), 1);
      lit("bounce_second", 32'(second), 0);
      repeat (100) @(negedge clk);
      lit("hold_minute", 32'(minute), 1);
      btn_min = 1'b0;
      repeat (10) @(negedge clk);

      // alarm minute stepping
      press(2);
      lit("set_alarm_on", 32'(set_alarm), 1);
      for (int i = 1; i <= 6; i++) begin
         press(1);
         lit("al_minute_step", 32'(al_minute), (i * 10) % 60);
      end
      press(2);
      lit("set_alarm_off", 32'(set_alarm), 0);

      // ring and acknowledge
      setup_110();
      repeat (582) @(negedge clk);
      lit("pre_alarm_second", 32'(second), 59);
      lit("pre_alarm_ring", 32'(alarm_ring), 0);
      repeat (10) @(negedge clk);
      lit("ring_on", 32'(alarm_ring), 1);
      lit("ring_second", 32'(second), 0);
      lit("ring_minute", 32'(minute), 10);
      press(2);
      lit("ack_ring", 32'(alarm_ring), 0);
      lit("ack_set_alarm", 32'(set_alarm), 0);

      // ring without acknowledge times out after RS ticks
      setup_110();
      repeat (592) @(negedge clk);
      lit("ring2_on", 32'(alarm_ring), 1);
      repeat (599) @(negedge clk);
      lit("ring2_last", 32'(alarm_ring), 1);
      @(negedge clk);
      lit("ring2_timeout", 32'(alarm_ring), 0);

      // ring cleared by the enable switch
      setup_110();
      repeat (592) @(negedge clk);
      alarm_en = 1'b0;
      repeat (3) @(negedge clk);
      lit("en_off_ring", 32'(alarm_ring), 0);

      // reset in the middle of a ring
      setup_110();
      repeat (597) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      lit("rst_ring", 32'(alarm_ring), 0);
      lit("rst_hour", 32'(hour), 0);
      lit("rst_minute", 32'(minute), 0);
      lit("rst_second", 32'(second), 0);
      lit("rst_al_hour", 32'(al_hour), 0);
      lit("rst_al_minute", 32'(al_minute), 0);
      lit("rst_slow", 32'(slow_clk), 0);
      lit("rst_set_alarm", 32'(set_alarm), 0);
      reset = 1'b1;
      alarm_en = 1'b0;

      // hour press lands in the tick cycle
      btn_min = 1'b1;
      repeat (7) @(posedge clk);
      @(negedge clk);
      btn_min = 1'b0;
      repeat (3) @(negedge clk);
      btn_hour = 1'b1;
      repeat (7) @(negedge clk);
      lit("collide_hour", 32'(hour), 1);
      lit("collide_second", 32'(second), 0);
      @(negedge clk);
      lit("deferred_tick_second", 32'(second), 1);
      btn_hour = 1'b0;
      repeat (10) @(negedge clk);

      // randomized buttons, bounces, switch and resets
      for (int i = 0; i < 160; i++) begin
         int b;
         b = $urandom_range(0, 3);
         for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
            set_btn(b, 1'($urandom_range(0, 1)));
            @(negedge clk);
         end
         set_btn(b, 1'b1);
         repeat ($urandom_range(2, 12)) @(negedge clk);
         set_btn(b, 1'b0);
         repeat ($urandom_range(1, 14)) @(negedge clk);
         if ($urandom_range(0, 9) == 0) alarm_en = ~alarm_en;
         if ($urandom_range(0, 49) == 0) do_reset();
      end

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clock_timekeeper.md
# clock_timekeeper

Timekeeping front end of the analog-clock display. Divides the system clock into a 1 Hz tick, maintains 12-hour time (h/m/s) and a 10-minute-granular alarm setting, debounces the three user buttons, and drives the clock renderer's `hour`, `minute`, `second`, `al_hour`, `al_minute` and `slow_clk` inputs plus an `alarm_ring` output for the buzzer/LED.

## Interface
- `TICK_DIV`, 25_000_000: `clk` cycles per second; must be at least 4.
- `DEBOUNCE_CYCLES`, 250_000: cycles a synchronized button level must stay stable before it is accepted.
- `RING_SECONDS`, 60: maximum duration of `alarm_ring` in seconds.
- `clk` in 1: system clock, the same clock as the renderer.
- `reset` in 1: one clock; reset is synchronous and active-low (0 = reset).
- `btn_hour` in 1: raw asynchronous push button; increments hour.
- `btn_min` in 1: raw push button; increments minute.
- `btn_mode` in 1: raw push button; toggles the set target between TIME and ALARM, and acknowledges a ringing alarm.
- `alarm_en` in 1: raw slide switch; enables the alarm. It is synchronized but not debounced.
- `hour` out 4: 0–11.
- `minute` out 6: 0–59.
- `second` out 6: 0–59.
- `al_hour` out 4: 0–11.
- `al_minute` out 6: one of 0, 10, 20, 30, 40, 50.
- `slow_clk` out 1: refresh strobe for the renderer; high for the first half of each second.
- `set_alarm` out 1: 1 when the set target is ALARM.
- `alarm_ring` out 1: alarm is sounding.

## Operation
- **Prescaler**
  - `presc` counts 0..TICK_DIV-1 and wraps.
  - `tick` is 1 for the cycle in which `presc` == TICK_DIV-1.
- **Debouncer, per button**
  - 2-FF synchronizer, then a stability counter.
  - The accepted level updates after DEBOUNCE_CYCLES consecutive equal samples.
  - Emits a 1-cycle `press` pulse on each accepted 0→1 transition.
  - Holding a button produces one press only; there is no auto-repeat.
- **Time counting on tick**
  - second+1.
  - On 59→0: minute+1.
  - On minute 59→0: hour+1.
  - On hour 11→0: wrap.
- **Set target TIME**
  - `btn_hour` press: hour+1, 11→0, no other effect.
  - `btn_min` press: minute+1, 59→0 with no carry into hour. Also sets second=0 and `presc`=0.
- **Set target ALARM**
  - `btn_hour` press: al_hour+1, 11→0.
  - `btn_min` press: al_minute+10, 50→0, no carry.
  - Time keeps running.
- **`btn_mode` press**
  - If `alarm_ring`=1: clears the ring only; the target is unchanged.
  - Otherwise: toggles the target.
- **Alarm FSM**
  - States: IDLE, RING.
  - IDLE→RING on the tick that makes hour==al_hour, minute==al_minute, second==0 while the synchronized `alarm_en`=1.
  - RING→IDLE on any of:
    - a `btn_mode` press;
    - `alarm_en` sampled 0;
    - RING_SECONDS ticks elapsed in RING.
  - The alarm does not re-arm until the next match.
  - Setting the time to a matching value with buttons does not trigger the alarm. Only a tick can.

## Timing
- **Reset values**, all outputs: hour=minute=second=0, al_hour=0, al_minute=0, `slow_clk`=0, `set_alarm`=0, `alarm_ring`=0.
- **Reset internal state**: `presc`=0, debouncers cleared to level 0, FSM in IDLE. Reset mid-count or mid-ring takes effect at the next clock edge and overrides all else.
- **Registered outputs**: all outputs are registered. Counters change on the clock edge after the cycle in which `tick`=1.
- **`slow_clk`**: rises on that same edge and stays high for TICK_DIV/2 cycles (integer division), then low until the next tick edge.
  - The renderer starts one refresh per rising edge.
  - The renderer refresh must be shorter than TICK_DIV/2 cycles.
- **Button latency**: a press takes effect 2 + DEBOUNCE_CYCLES + 1 cycles after the raw edge, worst case +1.
- **Tick and press in the same cycle**
  - The press is applied.
  - The tick is deferred by one cycle via a `tick_pending` flag and applied on the next cycle.
  - Exception: a TIME `btn_min` press discards the pending tick, because it resets `presc`.
  - No increment is ever lost or doubled.
- **Alarm timing**: `alarm_ring` rises on the same edge that second becomes 0 at the match.
- **Simultaneous `btn_hour` and `btn_min` presses**: both are applied in the same cycle.

## Structure
- **Package `clock_pkg`**:
  - constants MAX_HOUR=11, MAX_MIN=59, MAX_SEC=59, AL_MIN_STEP=10;
  - set-target encoding TGT_TIME=0, TGT_ALARM=1;
  - alarm FSM state encoding.
- **Sub-module `button_debouncer`** (parameter DEBOUNCE_CYCLES):
  - ports `clk`, `reset`, `btn_raw`, `level`, `press`;
  - instantiated three times.
- **Top level**: prescaler, `slow_clk` half-period counter, time/alarm counters and the alarm FSM stay in the top.

## Test plan
Use TICK_DIV=10 and DEBOUNCE_CYCLES=4 throughout.
- **Reset release, free run:** 10 cycles → second=1 and `slow_clk` high for exactly 5 cycles; after 600 cycles minute=1, second=0.
- **Hour wrap:** preload 11:59:58 via button presses, run 2 ticks → 0:00:00, no carry beyond hour.
- **Button bounce:** toggle `btn_min` every cycle for 3 cycles then hold high → exactly one press, so minute+1 and second=0; hold high for 100 cycles → no further increment.
- **Alarm set:** press `btn_mode`, then `btn_min` ×6 → al_minute 10,20,30,40,50,0; `set_alarm`=1; time counters unaffected apart from normal ticking.
- **Alarm ring:** set al=1:10, time 1:09:59, `alarm_en`=1; one tick → `alarm_ring`=1 with second=0; `btn_mode` press → `alarm_ring`=0 and `set_alarm` unchanged; second run with no ack → clears after 60 ticks.
- **Collision:** align a `btn_hour` press pulse with the `tick` cycle → hour+1 on that edge, second+1 exactly one cycle later; reset asserted during RING → all outputs return to reset values on the next edge.
